cache_controller: RTL and testbench
===================================

CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 Parameter NUM_LINES, default 16, number of direct-mapped lines with one 32-bit word per line.
REQ-002 Parameter CNT_W, default 16, width of the statistics counters.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 cpu_req  input  1  CPU access request, sampled only in IDLE.
REQ-006 cpu_we  input  1  1 = write, 0 = read.
REQ-007 cpu_addr  input  32  byte address; [1:0] ignored, index = [5:2], tag = [31:6] at the default parameter.
REQ-008 cpu_wdata  input  32  write data.
REQ-009 cpu_rdata  output  32  read data, valid while cpu_ready = 1.
REQ-010 cpu_ready  output  1  one-cycle completion pulse.
REQ-011 mem_req  output  1  memory request, held until mem_ack.
REQ-012 mem_we  output  1  1 = writeback, 0 = line fill.
REQ-013 mem_addr  output  32  word-aligned memory address.
REQ-014 mem_wdata  output  32  writeback data.
REQ-015 mem_rdata  input  32  fill data, valid with mem_ack.
REQ-016 mem_ack  input  1  one-cycle memory completion; ignored while mem_req = 0.
REQ-017 hit_count, miss_count  output  CNT_W  saturating statistics counters.

Function
REQ-018 The FSM SHALL have states IDLE, COMPARE, WRITEBACK and ALLOCATE, with a write-back, write-allocate policy.
REQ-019 IDLE with cpu_req = 1: register addr, we and wdata, then go to COMPARE. cpu_req is ignored in every other state.
REQ-020 Hit is defined as valid[index] && tag[index] == captured tag.
REQ-021 COMPARE on a read hit: cpu_ready = 1 and cpu_rdata = data[index] combinationally in that cycle; next state IDLE.
REQ-022 COMPARE on a write hit: write data[index] at the clock edge, set dirty = 1, pulse cpu_ready; next state IDLE.
REQ-023 Hit latency is exactly 2 cycles from the accepted request; peak throughput is one access per 2 cycles.
REQ-024 COMPARE on a miss with valid && dirty: go to WRITEBACK. On a miss with a clean or invalid line: go to ALLOCATE. cpu_ready stays 0.
REQ-025 WRITEBACK: mem_req = 1, mem_we = 1, mem_addr = {old tag, index, 2'b00}, mem_wdata = data[index]. On mem_ack, go to ALLOCATE.
REQ-026 ALLOCATE: mem_req = 1, mem_we = 0, mem_addr = {captured tag, index, 2'b00}. On mem_ack, write data = mem_rdata, tag, valid = 1, dirty = 0, then return to COMPARE, which then hits.
REQ-027 mem_addr, mem_we and mem_wdata SHALL stay stable while mem_req = 1. mem_req SHALL deassert in the cycle after mem_ack, and SHALL NOT be asserted in IDLE or COMPARE.
REQ-028 mem_ack arriving in the same cycle mem_req first rises (zero wait) SHALL be honoured. Any memory latency SHALL be tolerated.
REQ-029 hit_count increments only on a COMPARE hit reached directly from IDLE.
REQ-030 miss_count increments once per miss, on the COMPARE cycle that leaves for WRITEBACK or ALLOCATE.
REQ-031 Both counters saturate at 2^CNT_W-1 and do not wrap.
REQ-032 When cpu_ready = 0, cpu_rdata SHALL be 0.

Reset
REQ-033 rst_n = 0 SHALL immediately force: state IDLE, mem_req = 0, cpu_ready = 0, all valid and dirty bits = 0, counters = 0.
REQ-034 Tag and data arrays are not reset.
REQ-035 Reset during WRITEBACK or ALLOCATE SHALL abandon the transaction. mem_req SHALL drop asynchronously and the line SHALL not be updated.

Structure
REQ-036 Shared package cache_pkg SHALL hold: state encoding, NUM_LINES, INDEX_W = log2(NUM_LINES), TAG_W = 30 - INDEX_W, and the line-field slice constants.
REQ-037 Line storage (tag, valid, dirty, data) SHALL be one sub-module, cache_line_array. It has a single write port and an asynchronous read port; the FSM and counters stay in cache_controller.

Verification
REQ-038 After reset, read 0x0000_0040 with mem_rdata = 0xDEAD_BEEF and ack after 3 cycles -> one ALLOCATE, cpu_rdata = 0xDEADBEEF, miss_count = 1.
REQ-039 Read 0x0000_0040 again -> cpu_ready 2 cycles after the request, data 0xDEADBEEF, no mem_req, hit_count = 1.
REQ-040 Write 0x1234_5678 to 0x40, then read 0x0000_0080 (same index 0, different tag) -> WRITEBACK with mem_addr = 0x40 and mem_wdata = 0x12345678, then ALLOCATE at 0x80.
REQ-041 Zero-wait memory (mem_ack tied to mem_req) on a miss -> completes in 4 cycles, and mem_req never stays high after the ack.
REQ-042 Assert rst_n = 0 while mem_req = 1 in ALLOCATE, then reread the same address -> mem_req drops at once, and the reread misses (valid cleared).
REQ-043 Force hit_count to the saturation path (CNT_W = 4, 20 hits) -> hit_count holds at 15.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped cache controller.
// Provides the FSM state encoding, default geometry and the address field positions.
// Ports: none (package).
package cache_pkg;

  localparam int NUM_LINES = 16;
  localparam int INDEX_W   = $clog2(NUM_LINES);
  localparam int TAG_W     = 30 - INDEX_W;

  // Byte address layout: [1:0] byte offset, then index, then tag.
  localparam int INDEX_LSB = 2;
  localparam int TAG_LSB   = INDEX_LSB + INDEX_W;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_COMPARE   = 2'd1,
    ST_WRITEBACK = 2'd2,
    ST_ALLOCATE  = 2'd3
  } state_t;

endpackage

// File: rtl/cache_line_array.sv
// Line storage for the cache: tag, valid, dirty and one data word per line.
// Ports: index selects the line for both the asynchronous read and the single write port;
//        wr_en writes tag/data/dirty and marks the line valid. Only valid/dirty are reset.
module cache_line_array
  import cache_pkg::*;
#(
  parameter int NUM_LINES = cache_pkg::NUM_LINES,
  parameter int INDEX_W   = $clog2(NUM_LINES),
  parameter int TAG_W     = 30 - INDEX_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INDEX_W-1:0] index,
  output logic               rd_valid,
  output logic               rd_dirty,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [31:0]        rd_data,
  input  logic               wr_en,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [31:0]        wr_data,
  input  logic               wr_dirty
);

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [31:0]          data_q [NUM_LINES];

  assign rd_valid = valid_q[index];
  assign rd_dirty = dirty_q[index];
  assign rd_tag   = tag_q[index];
  assign rd_data  = data_q[index];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (wr_en) begin
      valid_q[index] <= 1'b1;
      dirty_q[index] <= wr_dirty;
    end
  end

  // Tag and data carry no reset; a cleared valid bit makes their contents irrelevant.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[index]  <= wr_tag;
      data_q[index] <= wr_data;
    end
  end

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped, write-back / write-allocate cache controller with hit/miss statistics.
// Ports: cpu_* is the single-outstanding CPU side (cpu_ready pulses on completion);
//        mem_* is the line fill / writeback side (mem_req held until mem_ack); hit/miss_count saturate.
module cache_controller #(
  parameter int NUM_LINES = cache_pkg::NUM_LINES,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [31:0]      cpu_addr,
  input  logic [31:0]      cpu_wdata,
  output logic [31:0]      cpu_rdata,
  output logic             cpu_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_ack,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  import cache_pkg::*;

  localparam int LINE_IDX_W   = $clog2(NUM_LINES);
  localparam int LINE_TAG_W   = 30 - LINE_IDX_W;
  localparam int LINE_TAG_LSB = INDEX_LSB + LINE_IDX_W;

  state_t                state, state_nxt;
  logic [LINE_IDX_W-1:0] cap_index;
  logic [LINE_TAG_W-1:0] cap_tag;
  logic                  cap_we;
  logic [31:0]           cap_wdata;
  logic                  after_fill;

  logic                  rd_valid, rd_dirty;
  logic [LINE_TAG_W-1:0] rd_tag;
  logic [31:0]           rd_data;
  logic                  wr_en, wr_dirty;
  logic [LINE_TAG_W-1:0] wr_tag;
  logic [31:0]           wr_data;

  logic                  hit, hit_inc, miss_inc;

  // Byte offset bits carry no information for word-sized lines.
  logic                  unused_byte_offset;
  assign unused_byte_offset = ^cpu_addr[INDEX_LSB-1:0];

  cache_line_array #(
    .NUM_LINES(NUM_LINES),
    .INDEX_W  (LINE_IDX_W),
    .TAG_W    (LINE_TAG_W)
  ) u_lines (
    .clk     (clk),
    .rst_n   (rst_n),
    .index   (cap_index),
    .rd_valid(rd_valid),
    .rd_dirty(rd_dirty),
    .rd_tag  (rd_tag),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_tag  (wr_tag),
    .wr_data (wr_data),
    .wr_dirty(wr_dirty)
  );

  assign hit = rd_valid && (rd_tag == cap_tag);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_index  <= '0;
      cap_tag    <= '0;
      cap_we     <= 1'b0;
      cap_wdata  <= '0;
      after_fill <= 1'b0;
    end else begin
      if (state == ST_IDLE && cpu_req) begin
        cap_index <= cpu_addr[INDEX_LSB +: LINE_IDX_W];
        cap_tag   <= cpu_addr[LINE_TAG_LSB +: LINE_TAG_W];
        cap_we    <= cpu_we;
        cap_wdata <= cpu_wdata;
      end
      // Marks the COMPARE that follows a fill, so its guaranteed hit is not counted.
      after_fill <= (state == ST_ALLOCATE) && mem_ack;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit_inc && hit_count != '1)   hit_count  <= hit_count + CNT_W'(1);
      if (miss_inc && miss_count != '1) miss_count <= miss_count + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    cpu_ready = 1'b0;
    cpu_rdata = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    wr_en     = 1'b0;
    wr_tag    = cap_tag;
    wr_data   = cap_wdata;
    wr_dirty  = 1'b1;
    hit_inc   = 1'b0;
    miss_inc  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cpu_req) state_nxt = ST_COMPARE;
      end
      ST_COMPARE: begin
        if (hit) begin
          cpu_ready = 1'b1;
          cpu_rdata = rd_data;
          wr_en     = cap_we;
          hit_inc   = !after_fill;
          state_nxt = ST_IDLE;
        end else begin
          miss_inc  = 1'b1;
          state_nxt = (rd_valid && rd_dirty) ? ST_WRITEBACK : ST_ALLOCATE;
        end
      end
      ST_WRITEBACK: begin
        // The victim line is untouched until the fill, so address/data stay stable.
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {rd_tag, cap_index, 2'b00};
        mem_wdata = rd_data;
        if (mem_ack) state_nxt = ST_ALLOCATE;
      end
      ST_ALLOCATE: begin
        mem_req  = 1'b1;
        mem_addr = {cap_tag, cap_index, 2'b00};
        if (mem_ack) begin
          wr_en     = 1'b1;
          wr_data   = mem_rdata;
          wr_dirty  = 1'b0;
          state_nxt = ST_COMPARE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_controller.sv
module tb_cache_controller;

  localparam int CW  = 4;
  localparam int SAT = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [31:0]   cpu_addr = '0;
  logic [31:0]   cpu_wdata = '0;
  logic [31:0]   cpu_rdata;
  logic          cpu_ready;
  logic          mem_req, mem_we, mem_ack;
  logic [31:0]   mem_addr, mem_wdata, mem_rdata;
  logic [CW-1:0] hit_count, miss_count;

  cache_controller #(.NUM_LINES(16), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int issue_cyc = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic finish_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  endtask

  function automatic logic [31:0] mem_init(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  // ---------------- memory responder ----------------
  logic [31:0] phys_mem [logic [31:0]];
  logic        zero_wait = 1'b0;
  int          mem_lat = 1;
  int          wait_cnt = 0;
  logic        ack_r = 1'b0;
  logic [31:0] rdata_r = '0;

  assign mem_ack   = zero_wait ? mem_req : ack_r;
  assign mem_rdata = rdata_r;

  function automatic logic [31:0] phys_rd(input logic [31:0] a);
    return phys_mem.exists(a) ? phys_mem[a] : mem_init(a);
  endfunction

  always @(posedge clk) begin
    #2;
    if (!rst_n || !mem_req) begin
      ack_r = 1'b0;
      wait_cnt = 0;
    end else begin
      rdata_r = phys_rd(mem_addr);
      if (zero_wait) begin
        if (mem_we) phys_mem[mem_addr] = mem_wdata;
        ack_r = 1'b0;
      end else begin
        if (ack_r) wait_cnt = 0;
        ack_r = 1'b0;
        if (wait_cnt >= mem_lat) begin
          ack_r = 1'b1;
          if (mem_we) phys_mem[mem_addr] = mem_wdata;
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  // ---------------- reference model (line view by word address) ----------------
  typedef struct {logic we; logic [31:0] addr; logic [31:0] wdata;} mem_exp_t;
  typedef struct {logic we; logic [31:0] rdata; int lat; int hits; int misses;} cpu_exp_t;
  mem_exp_t exp_mem[$];
  cpu_exp_t exp_cpu[$];

  bit          ref_v [16];
  bit          ref_d [16];
  logic [31:0] ref_waddr [16];
  logic [31:0] ref_data [16];
  logic [31:0] ref_mem [logic [31:0]];
  int          ref_hits = 0;
  int          ref_misses = 0;

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : mem_init(a);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      ref_v[i] = 1'b0;
      ref_d[i] = 1'b0;
    end
    ref_hits = 0;
    ref_misses = 0;
    exp_cpu.delete();
    exp_mem.delete();
  endtask

  task automatic model_access(input logic we, input logic [31:0] addr, input logic [31:0] wd, input int lat);
    int i;
    int total;
    logic [31:0] waddr;
    mem_exp_t m;
    cpu_exp_t c;
    i = int'((addr >> 2) % 16);
    waddr = {addr[31:2], 2'b00};
    total = 2;
    if (ref_v[i] && ref_waddr[i] == waddr) begin
      if (ref_hits < SAT) ref_hits++;
    end else begin
      if (ref_misses < SAT) ref_misses++;
      if (ref_v[i] && ref_d[i]) begin
        m.we = 1'b1; m.addr = ref_waddr[i]; m.wdata = ref_data[i];
        exp_mem.push_back(m);
        ref_mem[ref_waddr[i]] = ref_data[i];
        total += lat + 1;
      end
      m.we = 1'b0; m.addr = waddr; m.wdata = '0;
      exp_mem.push_back(m);
      ref_data[i] = ref_rd(waddr);
      ref_waddr[i] = waddr;
      ref_v[i] = 1'b1;
      ref_d[i] = 1'b0;
      total += lat + 2;
    end
    if (we) begin
      ref_data[i] = wd;
      ref_d[i] = 1'b1;
    end
    c.we = we; c.rdata = ref_data[i]; c.lat = total; c.hits = ref_hits; c.misses = ref_misses;
    exp_cpu.push_back(c);
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic        prev_req = 1'b0, prev_ack = 1'b0, prev_we = 1'b0;
  logic        cur_we = 1'b0;
  logic [31:0] cur_addr = '0, cur_wdata = '0;
  bit          cnt_pend = 1'b0;
  int          pend_hits = 0, pend_misses = 0;

  always @(negedge clk) begin
    cpu_exp_t e;
    mem_exp_t m;
    if (!rst_n) begin
      prev_req = 1'b0; prev_ack = 1'b0; prev_we = 1'b0; cnt_pend = 1'b0;
    end else begin
      if (cnt_pend) begin
        check("hit_count", 32'(hit_count), pend_hits);
        check("miss_count", 32'(miss_count), pend_misses);
        cnt_pend = 1'b0;
      end
      if (cpu_ready) begin
        check("cpu_ready_expected", 32'(exp_cpu.size() > 0), 1);
        if (exp_cpu.size() > 0) begin
          e = exp_cpu.pop_front();
          if (!e.we) check("cpu_rdata", cpu_rdata, e.rdata);
          check("latency", cyc - issue_cyc + 1, e.lat);
          pend_hits = e.hits;
          pend_misses = e.misses;
          cnt_pend = 1'b1;
        end
      end else begin
        check("rdata_zero_when_not_ready", cpu_rdata, 0);
      end
      if (prev_ack && !prev_we) check("mem_req_drop_after_fill", 32'(mem_req), 0);
      if (mem_req && (!prev_req || prev_ack)) begin
        check("mem_req_expected", 32'(exp_mem.size() > 0), 1);
        if (exp_mem.size() > 0) begin
          m = exp_mem.pop_front();
          check("mem_we", 32'(mem_we), 32'(m.we));
          check("mem_addr", mem_addr, m.addr);
          if (m.we) check("mem_wdata", mem_wdata, m.wdata);
        end
        cur_we = mem_we; cur_addr = mem_addr; cur_wdata = mem_wdata;
      end else if (mem_req) begin
        check("mem_addr_stable", mem_addr, cur_addr);
        check("mem_we_stable", 32'(mem_we), 32'(cur_we));
        check("mem_wdata_stable", mem_wdata, cur_wdata);
      end
      prev_req = mem_req; prev_ack = mem_ack; prev_we = mem_we;
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd, input int lat);
    @(posedge clk); #1;
    mem_lat = lat;
    model_access(we, addr, wd, zero_wait ? 0 : lat);
    issue_cyc = cyc;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    @(posedge clk); #1;
    // Garbage on the request lines after acceptance must be ignored.
    cpu_req = 1'b0; cpu_we = 1'($urandom); cpu_addr = $urandom; cpu_wdata = $urandom;
  endtask

  task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wd, input int lat);
    bit got;
    issue(we, addr, wd, lat);
    got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if (cpu_ready) got = 1'b1;
    end
    if (!got) begin
      check("cpu_ready_timeout", 32'(cpu_ready), 1);
      finish_run();
    end
  endtask

  initial begin
    bit seen;
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    check("reset_mem_req", 32'(mem_req), 0);
    check("reset_cpu_ready", 32'(cpu_ready), 0);
    check("reset_hit_count", 32'(hit_count), 0);
    check("reset_miss_count", 32'(miss_count), 0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;

    phys_mem[32'h40] = 32'hDEAD_BEEF;
    ref_mem[32'h40]  = 32'hDEAD_BEEF;

    do_access(1'b0, 32'h0000_0040, '0, 3);            // cold miss, fill after delay
    do_access(1'b0, 32'h0000_0040, '0, 3);            // hit, no memory traffic
    do_access(1'b1, 32'h0000_0040, 32'h1234_5678, 3); // write hit, line dirty
    do_access(1'b0, 32'h0000_0080, '0, 2);            // dirty victim: writeback 0x40, fill 0x80

    zero_wait = 1'b1;
    do_access(1'b0, 32'h0000_1104, '0, 0);            // clean miss, zero-wait memory
    do_access(1'b1, 32'h0000_1104, 32'hCAFE_F00D, 0);
    do_access(1'b0, 32'h0000_2106, '0, 0);            // dirty miss, zero-wait memory
    zero_wait = 1'b0;

    for (int k = 0; k < 20; k++) do_access(1'b0, 32'h0000_0080, '0, 1); // saturate hits

    // Reset while a fill is outstanding.
    issue(1'b0, 32'h0000_0100, '0, 12);
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk);
      if (mem_req && !mem_we) seen = 1'b1;
    end
    if (!seen) begin
      check("allocate_seen", 32'(mem_req), 1);
      finish_run();
    end
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("async_mem_req_drop", 32'(mem_req), 0);
    check("async_cpu_ready", 32'(cpu_ready), 0);
    check("async_hit_clear", 32'(hit_count), 0);
    check("async_miss_clear", 32'(miss_count), 0);
    model_reset();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    do_access(1'b0, 32'h0000_0100, '0, 1);            // must miss again

    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      a = (32'($urandom_range(0, 3)) << 28) | (32'($urandom_range(0, 1)) << 6) | ($urandom & 32'h3F);
      zero_wait = ($urandom_range(0, 3) == 0);
      do_access(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 4));
    end

    repeat (3) @(negedge clk);
    check("leftover_cpu_responses", exp_cpu.size(), 0);
    check("leftover_mem_requests", exp_mem.size(), 0);
    finish_run();
  end

endmodule
